// File: rtl/mac_operand_feeder_pkg.sv
// Shared definitions for the MAC operand feeder: sequencing states,
// precision encodings, data widths and the precision-to-period mapping.
package mac_operand_feeder_pkg;

   // Operand (activation / weight) width
   localparam int unsigned OPW  = 8;
   // Vector length field width
   localparam int unsigned LENW = 8;
   // Phase counter width, enough for the longest period (8 cycles)
   localparam int unsigned PHW  = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      PREC_8    = 2'b00,
      PREC_4    = 2'b01,
      PREC_2    = 2'b10,
      PREC_4ALT = 2'b11
   } prec_t;

   // Number of MAC-enabled cycles each operand pair is held for.
   function automatic logic [PHW:0] prec_period(input logic [1:0] prec);
      logic [PHW:0] p;
      case (prec)
         PREC_8:  p = (PHW+1)'(8);
         PREC_4:  p = (PHW+1)'(4);
         PREC_2:  p = (PHW+1)'(2);
         default: p = (PHW+1)'(4);
      endcase
      return p;
   endfunction

endpackage

// File: rtl/mac_operand_feeder_fifo.sv
// mac_pair_fifo: show-ahead FIFO of packed {activation, weight} pairs.
// Head entry is always visible on dout; full/empty decode registered occupancy.
module mac_pair_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Storage array: written on accepted push only, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally modulo DEPTH; occupancy tracks push/pop balance.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: buffers operand pairs and sequences a bit-serial MAC
// through clear, per-pair hold periods, a zero drain period and completion.
module mac_operand_feeder
   import mac_operand_feeder_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [1:0]      cfg_prec,
   input  logic [LENW-1:0] cfg_len,
   input  logic            start,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OPW-1:0]  in_act,
   input  logic [OPW-1:0]  in_wgt,
   output logic            mac_rstn,
   output logic            mac_en,
   output logic [1:0]      mac_prec,
   output logic [OPW-1:0]  mac_act,
   output logic [OPW-1:0]  mac_wgt,
   output logic            busy,
   output logic            vec_done
);

   state_t          state;
   logic [PHW-1:0]  ph;
   logic [LENW-1:0] rem;
   logic [PHW:0]    per;
   logic            rdy_q;
   logic            last_ph;
   logic            decide;
   logic            push;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [2*OPW-1:0] fifo_dout;

   // rdy_q is low through reset so in_ready stays deasserted until the
   // first edge with rstn high.
   assign in_ready = rdy_q & ~fifo_full;
   assign push     = in_valid & in_ready;
   assign per      = prec_period(mac_prec);
   assign last_ph  = ({1'b0, ph} == (per - (PHW+1)'(1)));

   // Outputs are registered, so the pair-boundary decision is taken at the
   // edge that ends a pair (or any edge while not enabled) and its result
   // is what the MAC sees in the following cycle.
   assign decide = (state == ST_RUN) && (!mac_en || last_ph);
   assign pop    = decide && (rem != '0) && !fifo_empty;

   mac_pair_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2*OPW)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .pop   (pop),
      .din   ({in_act, in_wgt}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Sequencer: state, phase, remaining-pair count and all MAC-side outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= ST_IDLE;
         ph       <= '0;
         rem      <= '0;
         rdy_q    <= 1'b0;
         mac_rstn <= 1'b0;
         mac_en   <= 1'b0;
         mac_prec <= PREC_8;
         mac_act  <= '0;
         mac_wgt  <= '0;
         busy     <= 1'b0;
         vec_done <= 1'b0;
      end else begin
         rdy_q    <= 1'b1;
         mac_rstn <= 1'b1;
         vec_done <= 1'b0;

         // Phase advances only on enabled cycles and wraps at the period.
         if (mac_en) begin
            ph <= last_ph ? '0 : ph + PHW'(1);
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (cfg_len != '0) begin
                     rem      <= cfg_len;
                     mac_prec <= cfg_prec;
                     mac_rstn <= 1'b0;
                     mac_act  <= '0;
                     mac_wgt  <= '0;
                     ph       <= '0;
                     state    <= ST_CLEAR;
                  end else begin
                     state <= ST_DONE;
                  end
               end
            end

            ST_CLEAR: begin
               ph    <= '0;
               state <= ST_RUN;
            end

            ST_RUN: begin
               if (decide) begin
                  if (rem == '0) begin
                     mac_en  <= 1'b1;
                     mac_act <= '0;
                     mac_wgt <= '0;
                     state   <= ST_DRAIN;
                  end else if (!fifo_empty) begin
                     mac_en  <= 1'b1;
                     mac_act <= fifo_dout[2*OPW-1:OPW];
                     mac_wgt <= fifo_dout[OPW-1:0];
                     rem     <= rem - LENW'(1);
                  end else begin
                     // Stall: operands and phase hold until a pair arrives.
                     mac_en <= 1'b0;
                  end
               end
            end

            ST_DRAIN: begin
               if (last_ph) begin
                  mac_en <= 1'b0;
                  state  <= ST_DONE;
               end
            end

            ST_DONE: begin
               vec_done <= 1'b1;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed testbench for mac_operand_feeder with hand-computed expectations.
module tb_mac_operand_feeder;

   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rstn;
   logic [1:0] cfg_prec;
   logic [7:0] cfg_len;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_act;
   logic [7:0] in_wgt;
   logic       mac_rstn;
   logic       mac_en;
   logic [1:0] mac_prec;
   logic [7:0] mac_act;
   logic [7:0] mac_wgt;
   logic       busy;
   logic       vec_done;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mac_operand_feeder #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .cfg_prec (cfg_prec),
      .cfg_len  (cfg_len),
      .start    (start),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_act   (in_act),
      .in_wgt   (in_wgt),
      .mac_rstn (mac_rstn),
      .mac_en   (mac_en),
      .mac_prec (mac_prec),
      .mac_act  (mac_act),
      .mac_wgt  (mac_wgt),
      .busy     (busy),
      .vec_done (vec_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic prefill(input logic [7:0] a, input logic [7:0] w);
      in_act   = a;
      in_wgt   = w;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !in_ready; i++) tick();
      tick();
      in_valid = 1'b0;
   endtask

   task automatic start_vec(input logic [1:0] p, input logic [7:0] l);
      cfg_prec = p;
      cfg_len  = l;
      start    = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; start = 1'b0; in_valid = 1'b0;
      cfg_prec = 2'b00; cfg_len = 8'd0; in_act = 8'd0; in_wgt = 8'd0;
      tick(); tick();
      tests++;
      if ({in_ready, mac_rstn, mac_en, busy, vec_done} !== 5'b00000) begin
         fails++;
         $display("FAIL reset_ctrl got=%b want=00000", {in_ready, mac_rstn, mac_en, busy, vec_done});
      end
      tests++;
      if ({mac_prec, mac_act, mac_wgt} !== 18'd0) begin
         fails++;
         $display("FAIL reset_data got prec=%b act=%h wgt=%h want 0", mac_prec, mac_act, mac_wgt);
      end
      rstn = 1'b1;
      tick();
      tests++;
      if ({in_ready, mac_rstn} !== 2'b11) begin
         fails++;
         $display("FAIL reset_release got ready,mac_rstn=%b want=11", {in_ready, mac_rstn});
      end
   endtask

   task automatic test_basic();
      logic       e_en, e_done;
      logic [7:0] e_act, e_wgt;
      int acc, ecnt;
      prefill(8'd3, 8'd5);
      prefill(8'd2, 8'd7);
      start_vec(2'b00, 8'd2);
      tests++;
      if ({mac_rstn, mac_en, busy, mac_prec} !== 5'b00100) begin
         fails++;
         $display("FAIL basic_clear got rstn,en,busy,prec=%b want=00100", {mac_rstn, mac_en, busy, mac_prec});
      end
      acc = 0; ecnt = 0;
      for (int c = 1; c <= 27; c++) begin
         tick();
         e_en   = (c >= 2 && c <= 25);
         e_act  = (c >= 2 && c <= 9) ? 8'd3 : (c >= 10 && c <= 17) ? 8'd2 : 8'd0;
         e_wgt  = (c >= 2 && c <= 9) ? 8'd5 : (c >= 10 && c <= 17) ? 8'd7 : 8'd0;
         e_done = (c == 27);
         tests++;
         if ({mac_rstn, mac_en, mac_act, mac_wgt, vec_done} !== {1'b1, e_en, e_act, e_wgt, e_done}) begin
            fails++;
            $display("FAIL basic_cycle%0d got rstn=%b en=%b act=%0d wgt=%0d done=%b want rstn=1 en=%b act=%0d wgt=%0d done=%b",
                     c, mac_rstn, mac_en, mac_act, mac_wgt, vec_done, e_en, e_act, e_wgt, e_done);
         end
         if (mac_en) begin
            if (ecnt % 8 == 0) acc += int'(mac_act) * int'(mac_wgt);
            ecnt++;
         end
      end
      tests++;
      if (acc !== 29) begin
         fails++;
         $display("FAIL basic_result got=%0d want=29", acc);
      end
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL basic_busy_end got=%b want=0", busy);
      end
   endtask

   task automatic test_gaps();
      logic [21:1] en_exp;
      logic [7:0]  e_act, e_wgt;
      en_exp = 21'b001111000011000011000;
      start_vec(2'b10, 8'd3);
      tests++;
      if (mac_prec !== 2'b10) begin
         fails++;
         $display("FAIL gaps_prec got=%b want=10", mac_prec);
      end
      for (int c = 1; c <= 21; c++) begin
         tick();
         e_act = (c <= 3) ? 8'h00 : (c <= 9) ? 8'h11 : (c <= 15) ? 8'h33 : (c <= 17) ? 8'h55 : 8'h00;
         e_wgt = (c <= 3) ? 8'h00 : (c <= 9) ? 8'h22 : (c <= 15) ? 8'h44 : (c <= 17) ? 8'h66 : 8'h00;
         tests++;
         if ({mac_en, mac_act, mac_wgt, vec_done} !== {en_exp[c], e_act, e_wgt, (c == 21)}) begin
            fails++;
            $display("FAIL gaps_cycle%0d got en=%b act=%h wgt=%h done=%b want en=%b act=%h wgt=%h done=%b",
                     c, mac_en, mac_act, mac_wgt, vec_done, en_exp[c], e_act, e_wgt, (c == 21));
         end
         in_valid = (c == 2 || c == 8 || c == 14);
         in_act   = (c == 2) ? 8'h11 : (c == 8) ? 8'h33 : 8'h55;
         in_wgt   = (c == 2) ? 8'h22 : (c == 8) ? 8'h44 : 8'h66;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_zero_len();
      prefill(8'd9, 8'd6);
      start_vec(2'b01, 8'd0);
      tests++;
      if ({busy, mac_en, mac_rstn, vec_done, in_ready} !== 5'b10101) begin
         fails++;
         $display("FAIL zero_done_state got busy,en,rstn,done,ready=%b want=10101", {busy, mac_en, mac_rstn, vec_done, in_ready});
      end
      tick();
      tests++;
      if ({vec_done, busy, mac_en, mac_rstn} !== 4'b1001) begin
         fails++;
         $display("FAIL zero_pulse got done,busy,en,rstn=%b want=1001", {vec_done, busy, mac_en, mac_rstn});
      end
      tick();
      tests++;
      if (vec_done !== 1'b0) begin
         fails++;
         $display("FAIL zero_pulse_width got=%b want=0", vec_done);
      end
      // The queued pair must still be there for the next real vector.
      start_vec(2'b10, 8'd1);
      for (int c = 1; c <= 7; c++) begin
         tick();
         tests++;
         if ({mac_en, mac_act, mac_wgt, vec_done} !==
             {(c >= 2 && c <= 5), ((c == 2 || c == 3) ? 8'd9 : 8'd0), ((c == 2 || c == 3) ? 8'd6 : 8'd0), (c == 7)}) begin
            fails++;
            $display("FAIL zero_next_cycle%0d got en=%b act=%0d wgt=%0d done=%b", c, mac_en, mac_act, mac_wgt, vec_done);
         end
      end
   endtask

   task automatic test_full();
      logic [7:0] e_act, e_wgt;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_act   = 8'h10 + 8'(i);
         in_wgt   = 8'h20 + 8'(i);
         tick();
      end
      tests++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL full_ready got=%b want=0", in_ready);
      end
      in_act = 8'h14; in_wgt = 8'h24;
      start_vec(2'b10, 8'd5);
      tests++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL full_ready_clear got=%b want=0", in_ready);
      end
      for (int c = 1; c <= 15; c++) begin
         tick();
         if (c == 3) in_valid = 1'b0;
         if (c <= 2) begin
            tests++;
            if (in_ready !== (c == 2)) begin
               fails++;
               $display("FAIL full_ready_cycle%0d got=%b want=%b", c, in_ready, (c == 2));
            end
         end
         e_act = (c >= 2 && c <= 11) ? 8'h10 + 8'((c - 2) / 2) : 8'h00;
         e_wgt = (c >= 2 && c <= 11) ? 8'h20 + 8'((c - 2) / 2) : 8'h00;
         tests++;
         if ({mac_en, mac_act, mac_wgt, vec_done} !== {(c >= 2 && c <= 13), e_act, e_wgt, (c == 15)}) begin
            fails++;
            $display("FAIL full_cycle%0d got en=%b act=%h wgt=%h done=%b want en=%b act=%h wgt=%h done=%b",
                     c, mac_en, mac_act, mac_wgt, vec_done, (c >= 2 && c <= 13), e_act, e_wgt, (c == 15));
         end
      end
   endtask

   task automatic test_reset_mid();
      int  dones;
      logic seen;
      prefill(8'd1, 8'd1);
      prefill(8'd2, 8'd2);
      prefill(8'd3, 8'd3);
      start_vec(2'b00, 8'd3);
      dones = 0;
      for (int c = 1; c <= 13; c++) begin
         tick();
         if (vec_done) dones++;
      end
      tests++;
      if ({mac_en, mac_act} !== {1'b1, 8'd2}) begin
         fails++;
         $display("FAIL rmid_pair2 got en=%b act=%0d want en=1 act=2", mac_en, mac_act);
      end
      rstn = 1'b0;
      tick();
      if (vec_done) dones++;
      tests++;
      if ({in_ready, mac_rstn, mac_en, busy, vec_done, mac_prec, mac_act, mac_wgt} !== 23'd0) begin
         fails++;
         $display("FAIL rmid_outputs got ready=%b rstn=%b en=%b busy=%b done=%b prec=%b act=%h wgt=%h want all 0",
                  in_ready, mac_rstn, mac_en, busy, vec_done, mac_prec, mac_act, mac_wgt);
      end
      rstn = 1'b1;
      tick();
      if (vec_done) dones++;
      tests++;
      if (dones !== 0) begin
         fails++;
         $display("FAIL rmid_no_done got=%0d want=0", dones);
      end
      start_vec(2'b10, 8'd1);
      for (int c = 1; c <= 6; c++) begin
         tick();
         tests++;
         if ({mac_en, busy} !== 2'b01) begin
            fails++;
            $display("FAIL rmid_empty_cycle%0d got en,busy=%b want=01", c, {mac_en, busy});
         end
      end
      prefill(8'h44, 8'h55);
      seen = 1'b0;
      dones = 0;
      for (int c = 0; c < 20 && dones == 0; c++) begin
         tick();
         if (mac_en && mac_act == 8'h44 && mac_wgt == 8'h55) seen = 1'b1;
         if (vec_done) dones++;
      end
      tests++;
      if ({seen, dones} !== {1'b1, 32'd1}) begin
         fails++;
         $display("FAIL rmid_recover got seen=%b dones=%0d want seen=1 dones=1", seen, dones);
      end
   endtask

   task automatic test_config();
      int ens, dones, done_cyc;
      for (int i = 0; i < 4; i++) prefill(8'(i + 1), 8'(i + 8'h11));
      start_vec(2'b01, 8'd4);
      ens = 0; dones = 0; done_cyc = -1;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (mac_en) ens++;
         if (vec_done) begin
            dones++;
            done_cyc = c;
         end
         if (c >= 2 && c <= 17) begin
            tests++;
            if (mac_act !== 8'((c - 2) / 4 + 1)) begin
               fails++;
               $display("FAIL cfg_hold_cycle%0d got act=%0d want=%0d", c, mac_act, (c - 2) / 4 + 1);
            end
         end
         if (c == 5) begin
            cfg_prec = 2'b00;
            cfg_len  = 8'd1;
            start    = 1'b1;
         end
         if (c == 8) start = 1'b0;
      end
      tests++;
      if (ens !== 20) begin
         fails++;
         $display("FAIL cfg_en_count got=%0d want=20", ens);
      end
      tests++;
      if ({dones, done_cyc} !== {32'd1, 32'd23}) begin
         fails++;
         $display("FAIL cfg_done got count=%0d cycle=%0d want count=1 cycle=23", dones, done_cyc);
      end
      tests++;
      if (mac_prec !== 2'b01) begin
         fails++;
         $display("FAIL cfg_prec_latched got=%b want=01", mac_prec);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_zero_len();
      test_full();
      test_reset_mid();
      test_config();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mac_operand_feeder.md
MAC_OPERAND_FEEDER -- requirements
Module: mac_operand_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the operand-pair buffer depth (power of two, at least 2).
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rstn  in  1  synchronous, active-low reset.
- cfg_prec  in  2  precision level: 00 = 8 bits, 01 = 4, 10 = 2, 11 = 4.
- cfg_len  in  8  operand pairs per vector.
- start  in  1  begin vector; sampled only in IDLE.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  buffer can accept a pair.
- in_act  in  8  activation.
- in_wgt  in  8  weight.
- mac_rstn  out  1  MAC clear, active-low.
- mac_en  out  1  MAC enable.
- mac_prec  out  2  latched precision to the MAC.
- mac_act  out  8  activation to the MAC.
- mac_wgt  out  8  weight to the MAC.
- busy  out  1  vector in progress.
- vec_done  out  1  one-cycle pulse when the vector is complete.

Function
REQ-003 SHALL accept a pair on any cycle where in_valid && in_ready, in every state, including prefill in IDLE.
REQ-004 in_ready SHALL equal "buffer not full" from registered state; a pop in the same cycle does not raise it.
REQ-005 SHALL use the states IDLE, CLEAR, RUN, DRAIN and DONE.
REQ-006 IDLE with start=1 and cfg_len!=0 SHALL latch cfg_len and cfg_prec (to mac_prec) and go to CLEAR.
REQ-007 IDLE with start=1 and cfg_len=0 SHALL go to DONE, with no CLEAR and no mac_en.
REQ-008 CLEAR SHALL last exactly 1 cycle with mac_rstn=0 and mac_en=0, then go to RUN.
REQ-009 The bit period P SHALL be 8/4/2/4 cycles for latched prec 00/01/10/11.
REQ-010 A phase counter SHALL count 0..P-1 on mac_en=1 cycles only, wrap to 0, and clear in CLEAR.
REQ-011 In RUN at phase 0 with the buffer non-empty, the block SHALL pop one pair into mac_act/mac_wgt registers and assert mac_en.
REQ-012 The popped pair SHALL hold on mac_act/mac_wgt for P mac_en cycles.
REQ-013 In RUN at phase 0 with the buffer empty, mac_en SHALL be 0 (stall), with operands and phase held; the MAC count stays aligned.
REQ-014 mac_en SHALL never deassert at phase != 0 once a pair has started.
REQ-015 After the latched length of pairs completes P cycles each, the block SHALL go to DRAIN.
REQ-016 DRAIN SHALL present act=0, wgt=0 with mac_en=1 for exactly P cycles, so the MAC's first-bit transition accumulates the final product, then go to DONE.
REQ-017 DONE SHALL assert vec_done for 1 cycle and return to IDLE.
REQ-018 busy SHALL be 1 in CLEAR, RUN, DRAIN and DONE, and 0 in IDLE.
REQ-019 start while busy SHALL be ignored.
REQ-020 cfg_prec and cfg_len changes mid-vector SHALL be ignored.
REQ-021 Buffered pairs beyond the latched length SHALL remain queued, in order, for the next vector.
REQ-022 Buffer pointers SHALL wrap modulo DEPTH.
REQ-023 Simultaneous push and pop SHALL keep the occupancy unchanged.
REQ-024 Push when full and pop when empty SHALL never occur.
REQ-025 mac_act and mac_wgt SHALL be 0 whenever mac_en=0 outside a stall; a stall holds the last operands.

Reset
REQ-026 rstn=0 at a clock edge SHALL force: state IDLE, buffer empty, phase 0, in_ready=0 during reset, mac_rstn=0, mac_en=0, mac_prec=00, mac_act=0, mac_wgt=0, busy=0, vec_done=0.
REQ-027 in_ready SHALL be 1 on the first cycle after rstn returns high.
REQ-028 mac_rstn SHALL return to 1 in that same first cycle.
REQ-029 Reset mid-vector SHALL abort with no vec_done pulse and discard all buffered pairs.
REQ-030 All outputs SHALL be registered, except in_ready, which is decoded from registered occupancy.

Structure
REQ-031 A shared package SHALL hold:
- the state enumeration;
- the precision encodings;
- a function mapping prec to period P;
- operand width constant 8;
- length width constant 8.
REQ-032 The buffer SHALL be a sub-module, mac_pair_fifo: 16-bit entries, DEPTH parameter, push/pop/full/empty.
REQ-033 All sequencing SHALL stay in mac_operand_feeder.

Verification
REQ-034 Scenario, basic 8-bit vector:
- Stimulus: prec=00, len=2, prefill (3,5),(2,7); start.
- Response: CLEAR 1 cycle; 16 mac_en cycles of pairs; 8 DRAIN cycles of zeros.
- Response: vec_done 27 cycles after the start edge; MAC RESULT=29.
REQ-035 Scenario, 2-bit vector with gaps:
- Stimulus: prec=10, len=3, pairs fed with 5-cycle gaps.
- Response: mac_en low only at phase 0 during gaps.
- Response: each pair held exactly 2 en-cycles; no mid-pair drop.
REQ-036 Scenario, zero length:
- Stimulus: start with len=0.
- Response: vec_done the cycle after DONE entry; mac_en and mac_rstn untouched; buffer unchanged.
REQ-037 Scenario, full buffer:
- Stimulus: DEPTH=4; push 5 pairs back-to-back in IDLE.
- Response: in_ready=0 after 4; the 5th pair is accepted only after the first RUN pop.
- Response: order preserved.
REQ-038 Scenario, reset mid-vector:
- Stimulus: rstn low at RUN phase 3 of the second pair.
- Response: all outputs take reset values at that edge; no vec_done; buffer empty afterwards.
REQ-039 Scenario, config changes during a vector:
- Stimulus: start with prec=01, len=4; change cfg_prec to 00 and pulse start mid-vector.
- Response: P stays 4; second start ignored; exactly one vec_done.
